// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per channel over a window and maps counts to pixel intensities.
// Define SPIKE_DEC_ARGMAX_EN to add the argmax SCAN stage (winner_idx / winner_tie).
module spike_rate_decoder #(
  parameter int NUM_CH    = 4,
  parameter int WINDOW    = 16,
  parameter int OUT_WIDTH = 8,
  localparam int CNT_WIDTH = $clog2(WINDOW + 1),
  localparam int IDX_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           spike_valid,
  input  logic [NUM_CH-1:0]              spike_in,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*OUT_WIDTH-1:0]    pixel_out,
  output logic [NUM_CH*CNT_WIDTH-1:0]    spike_count,
  output logic [IDX_WIDTH-1:0]           winner_idx,
  output logic                           winner_tie
);

  localparam int PW      = CNT_WIDTH + OUT_WIDTH + 1;
  localparam int SCALE   = (1 << OUT_WIDTH) / WINDOW;
  localparam int MAX_PIX = (1 << OUT_WIDTH) - 1;
  localparam logic [CNT_WIDTH-1:0] LP_WINDOW = CNT_WIDTH'(WINDOW);

  typedef enum logic [1:0] {StIdle, StAccum, StScan, StHold} state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_CH];
  logic [CNT_WIDTH-1:0] r_samples;
  logic                 r_busy;
  logic                 r_out_valid;
  logic                 w_start_ok;

`ifdef SPIKE_DEC_ARGMAX_EN
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CH - 1);
  logic [IDX_WIDTH-1:0] r_scan_idx;
  logic [IDX_WIDTH-1:0] r_best_idx;
  logic [CNT_WIDTH-1:0] r_best_cnt;
  logic                 r_tie;
  logic [CNT_WIDTH-1:0] w_scan_cnt;

  assign w_scan_cnt = r_cnt[r_scan_idx];
`endif

  assign w_start_ok = start & ((r_state == StIdle) | ((r_state == StHold) & out_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_samples   <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
`ifdef SPIKE_DEC_ARGMAX_EN
      r_scan_idx  <= '0;
      r_best_idx  <= '0;
      r_best_cnt  <= '0;
      r_tie       <= 1'b0;
`endif
    end else begin
      if (w_start_ok) begin
        r_samples <= '0;
        for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
`ifdef SPIKE_DEC_ARGMAX_EN
        r_best_idx <= '0;
        r_best_cnt <= '0;
        r_tie      <= 1'b0;
`endif
      end
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StAccum;
            r_busy  <= 1'b1;
          end
        end
        StAccum: begin
          // A full window waits one cycle here before leaving ACCUM.
          if (r_samples == LP_WINDOW) begin
`ifdef SPIKE_DEC_ARGMAX_EN
            r_state    <= StScan;
            r_scan_idx <= '0;
`else
            r_state     <= StHold;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
`endif
          end else if (spike_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (spike_in[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            r_samples <= r_samples + 1'b1;
          end
        end
`ifdef SPIKE_DEC_ARGMAX_EN
        StScan: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if ((r_scan_idx == '0) || (w_scan_cnt > r_best_cnt)) begin
            r_best_cnt <= w_scan_cnt;
            r_best_idx <= r_scan_idx;
            r_tie      <= 1'b0;
          end else if (w_scan_cnt == r_best_cnt) begin
            r_tie <= 1'b1;
          end
          if (r_scan_idx == LAST_IDX) begin
            r_state     <= StHold;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
`endif
        StHold: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (start) begin
              r_state <= StAccum;
              r_busy  <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: begin
          r_state     <= StIdle;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PW-1:0] w_prod;
    assign w_prod = PW'(r_cnt[g]) * PW'(SCALE);
    assign pixel_out[g*OUT_WIDTH +: OUT_WIDTH] =
        (w_prod > PW'(MAX_PIX)) ? {OUT_WIDTH{1'b1}} : w_prod[OUT_WIDTH-1:0];
    assign spike_count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;

`ifdef SPIKE_DEC_ARGMAX_EN
  assign winner_idx = r_best_idx;
  assign winner_tie = r_tie;
`else
  assign winner_idx = '0;
  assign winner_tie = 1'b0;
`endif

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of spike channels decoded in parallel.
REQ-002 SHALL have parameter WINDOW, default 16: spike samples per decode window; power of two, 2..256.
REQ-003 SHALL have parameter OUT_WIDTH, default 8: width of each decoded intensity.
REQ-004 SHALL have derived localparams CNT_WIDTH = $clog2(WINDOW+1) and IDX_WIDTH = max(1, $clog2(NUM_CH)).
REQ-005 SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 start  input  1  request a new decode window; honoured only in IDLE, or in HOLD together with the out handshake.
REQ-009 spike_valid  input  1  strobe marking one spike sample on spike_in.
REQ-010 spike_in  input  NUM_CH  spike bit per channel, sampled when spike_valid=1.
REQ-011 busy  output  1  high in ACCUM and SCAN.
REQ-012 out_valid  output  1  decoded result available (HOLD state).
REQ-013 out_ready  input  1  consumer accepts result; handshake = out_valid & out_ready.
REQ-014 pixel_out  output  NUM_CH x OUT_WIDTH  decoded intensity per channel.
REQ-015 spike_count  output  NUM_CH x CNT_WIDTH  raw spike count per channel.
REQ-016 winner_idx  output  IDX_WIDTH  channel with the highest count.
REQ-017 winner_tie  output  1  another channel equals the winning count.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM, SCAN and HOLD.
REQ-019 IDLE: start=1 clears all counters and the sample counter, then moves to ACCUM on the next edge.
REQ-020 ACCUM: each cycle with spike_valid=1 increments counter[i] for every i where spike_in[i]=1, and increments the sample counter.
REQ-021 ACCUM: when the WINDOW-th sample is accepted, the FSM moves to SCAN on the next edge.
REQ-022 SCAN: one channel is compared per cycle, index 0..NUM_CH-1; after NUM_CH cycles the FSM moves to HOLD.
REQ-023 Result latency SHALL be NUM_CH+1 cycles from the edge sampling the last spike to out_valid=1.
REQ-024 Argmax rule: strictly-greater replaces the current best, so the lowest index wins ties; winner_tie=1 if any other channel equals the final maximum.
REQ-025 Decoding: pixel_out[i] = min(count[i] * (2^OUT_WIDTH / WINDOW), 2^OUT_WIDTH - 1); with defaults, 16 spikes gives 255, 8 gives 128 and 0 gives 0.
REQ-026 HOLD: out_valid=1; pixel_out, spike_count, winner_idx and winner_tie SHALL stay stable until the handshake.
REQ-027 On the handshake the FSM goes to IDLE; if start=1 in the same cycle, it goes directly to ACCUM with cleared counters.
REQ-028 spike_valid SHALL be ignored outside ACCUM (no count, no error); start SHALL be ignored in ACCUM and SCAN.
REQ-029 Counters SHALL never wrap, since the maximum count equals WINDOW, which fits in CNT_WIDTH.

Reset
REQ-030 While rst=1 the FSM SHALL be IDLE and all counters 0.
REQ-031 While rst=1, busy, out_valid, pixel_out, spike_count, winner_idx and winner_tie SHALL all be 0.
REQ-032 rst asserted mid-window or in HOLD SHALL discard all partial results immediately; no out_valid follows.

Configuration
REQ-033 Macro SPIKE_DEC_ARGMAX_EN defined: SCAN state, winner_idx and winner_tie are implemented as above.
REQ-034 Macro SPIKE_DEC_ARGMAX_EN undefined: SCAN is omitted, ACCUM goes directly to HOLD, and latency is 1 cycle.
REQ-035 Macro SPIKE_DEC_ARGMAX_EN undefined: winner_idx and winner_tie are tied to 0.

Verification
REQ-036 Defaults; start, then 16 samples with channels 0..3 spiking 2, 4, 8 and 16 times -> counts 2/4/8/16, pixel_out 32/64/128/255, winner_idx=3, winner_tie=0.
REQ-037 All channels spike 5 times -> pixel_out all 80, winner_idx=0, winner_tie=1.
REQ-038 16 samples, out_ready held 0 for 10 cycles -> outputs stable and out_valid=1 throughout; a further start is not honoured until the handshake.
REQ-039 Gaps in spike_valid plus spike_valid pulses in IDLE and HOLD -> only the 16 ACCUM samples are counted; out_valid comes exactly NUM_CH+1 cycles after the last sample.
REQ-040 rst pulsed after 9 samples -> all outputs 0 and the FSM in IDLE; a new start and a full window give correct results.
REQ-041 Handshake with start=1 in the same cycle -> busy=1 on the next cycle, counters 0, and the next window is decoded correctly; repeat with SPIKE_DEC_ARGMAX_EN undefined to confirm 1-cycle latency.
